// File: rtl/ddr_param_bank_if.sv
// Host-side config write port for ddr_param_bank: valid/ready handshake plus error pulse.
interface ddr_param_bank_if #(
    parameter int CH_ID_W = 2,
    parameter int DATA_W  = 64
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_ID_W-1:0] cfg_ch;
    logic [3:0]         cfg_id;
    logic [DATA_W-1:0]  cfg_data;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_id, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_id, cfg_data,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/ddr_param_bank.sv
// Per-channel shadow/active parameter bank with busy-deferred commit.
// Optional shadow readback port enabled by DDR_PARAM_READBACK_EN.
module ddr_param_bank #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_W     = 64,
    parameter int NUM_CH     = 2,
    parameter int CH_ID_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    ddr_param_bank_if.slave              cfg,
    input  logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH-1:0]            ch_start,
    output logic [NUM_CH-1:0]            ch_pending,
    output logic [NUM_CH*32-1:0]         act_ops,
    output logic [NUM_CH*32-1:0]         act_stride,
    output logic [NUM_CH*ADDR_WIDTH-1:0] act_addr,
    output logic [NUM_CH*16-1:0]         act_burst,
    output logic [NUM_CH*32-1:0]         act_length,
    output logic [NUM_CH*4-1:0]          act_mode
`ifdef DDR_PARAM_READBACK_EN
    ,
    input  logic [CH_ID_W-1:0]           rd_ch,
    input  logic [3:0]                   rd_id,
    output logic [DATA_W-1:0]            rd_data
`endif
);

    localparam int USED_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    logic [31:0]           sh_ops_q    [NUM_CH];
    logic [31:0]           sh_stride_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] sh_addr_q   [NUM_CH];
    logic [15:0]           sh_burst_q  [NUM_CH];
    logic [31:0]           sh_length_q [NUM_CH];
    logic [3:0]            sh_mode_q   [NUM_CH];

    logic [31:0]           ac_ops_q    [NUM_CH];
    logic [31:0]           ac_stride_q [NUM_CH];
    logic [ADDR_WIDTH-1:0] ac_addr_q   [NUM_CH];
    logic [15:0]           ac_burst_q  [NUM_CH];
    logic [31:0]           ac_length_q [NUM_CH];
    logic [3:0]            ac_mode_q   [NUM_CH];

    logic [NUM_CH-1:0] pending_q, start_q, commit_req, load;
    logic              err_q;
    logic              ch_ok, id_ok, burst_zero, xfer, wr_ok;

    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(cfg.cfg_ch) == c) cfg.cfg_ready = !pending_q[c];
        end
        ch_ok      = int'(cfg.cfg_ch) < NUM_CH;
        id_ok      = (cfg.cfg_id inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hF});
        burst_zero = (cfg.cfg_id == 4'h4) && (cfg.cfg_data[15:0] == 16'h0);
        xfer       = cfg.cfg_valid && cfg.cfg_ready;
        wr_ok      = xfer && ch_ok && id_ok && !burst_zero;
        commit_req = '0;
        load       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            commit_req[c] = wr_ok && (cfg.cfg_id == 4'hF) && (int'(cfg.cfg_ch) == c);
            // Copy on an idle commit, or on the first idle edge after a deferred one
            load[c] = !ch_busy[c] && (commit_req[c] || pending_q[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            pending_q <= '0;
            start_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_ops_q[c]    <= '0;
                sh_stride_q[c] <= '0;
                sh_addr_q[c]   <= '0;
                sh_burst_q[c]  <= '0;
                sh_length_q[c] <= '0;
                sh_mode_q[c]   <= '0;
                ac_ops_q[c]    <= '0;
                ac_stride_q[c] <= '0;
                ac_addr_q[c]   <= '0;
                ac_burst_q[c]  <= '0;
                ac_length_q[c] <= '0;
                ac_mode_q[c]   <= '0;
            end
        end else begin
            err_q <= xfer && !wr_ok;
            for (int c = 0; c < NUM_CH; c++) begin
                start_q[c] <= load[c];
                if (commit_req[c] && ch_busy[c]) begin
                    pending_q[c] <= 1'b1;
                end else if (load[c]) begin
                    pending_q[c] <= 1'b0;
                end
                if (load[c]) begin
                    ac_ops_q[c]    <= sh_ops_q[c];
                    ac_stride_q[c] <= sh_stride_q[c];
                    ac_addr_q[c]   <= sh_addr_q[c];
                    ac_burst_q[c]  <= sh_burst_q[c];
                    ac_length_q[c] <= sh_length_q[c];
                    ac_mode_q[c]   <= sh_mode_q[c];
                end
                if (wr_ok && int'(cfg.cfg_ch) == c) begin
                    case (cfg.cfg_id)
                        4'h1:    sh_ops_q[c]    <= cfg.cfg_data[31:0];
                        4'h2:    sh_stride_q[c] <= cfg.cfg_data[31:0];
                        4'h3:    sh_addr_q[c]   <= cfg.cfg_data[ADDR_WIDTH-1:0];
                        4'h4:    sh_burst_q[c]  <= cfg.cfg_data[15:0];
                        4'h5:    sh_length_q[c] <= cfg.cfg_data[31:0];
                        4'h6:    sh_mode_q[c]   <= cfg.cfg_data[3:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign cfg.cfg_err = err_q;
    assign ch_start    = start_q;
    assign ch_pending  = pending_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_act
        assign act_ops[g*32 +: 32]                 = ac_ops_q[g];
        assign act_stride[g*32 +: 32]              = ac_stride_q[g];
        assign act_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = ac_addr_q[g];
        assign act_burst[g*16 +: 16]               = ac_burst_q[g];
        assign act_length[g*32 +: 32]              = ac_length_q[g];
        assign act_mode[g*4 +: 4]                  = ac_mode_q[g];
    end

    if (DATA_W > USED_W) begin : g_unused
        logic unused_data;
        assign unused_data = ^cfg.cfg_data[DATA_W-1:USED_W];
    end

`ifdef DDR_PARAM_READBACK_EN
    logic [DATA_W-1:0] rd_d, rd_q;

    always_comb begin
        rd_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(rd_ch) == c) begin
                case (rd_id)
                    4'h1:    rd_d = DATA_W'(sh_ops_q[c]);
                    4'h2:    rd_d = DATA_W'(sh_stride_q[c]);
                    4'h3:    rd_d = DATA_W'(sh_addr_q[c]);
                    4'h4:    rd_d = DATA_W'(sh_burst_q[c]);
                    4'h5:    rd_d = DATA_W'(sh_length_q[c]);
                    4'h6:    rd_d = DATA_W'(sh_mode_q[c]);
                    default: rd_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_ddr_param_bank.sv
// Directed self-checking bench for ddr_param_bank (two channels, default widths).
module tb_ddr_param_bank;

    localparam int ADDR_WIDTH = 33;
    localparam int DATA_W     = 64;
    localparam int NUM_CH     = 2;
    localparam int CH_ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_CH-1:0]            ch_busy = '0;
    logic [NUM_CH-1:0]            ch_start, ch_pending;
    logic [NUM_CH*32-1:0]         act_ops, act_stride, act_length;
    logic [NUM_CH*ADDR_WIDTH-1:0] act_addr;
    logic [NUM_CH*16-1:0]         act_burst;
    logic [NUM_CH*4-1:0]          act_mode;
`ifdef DDR_PARAM_READBACK_EN
    logic [CH_ID_W-1:0] rd_ch = '0;
    logic [3:0]         rd_id = '0;
    logic [DATA_W-1:0]  rd_data;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr_param_bank_if #(.CH_ID_W(CH_ID_W), .DATA_W(DATA_W)) cfg_if ();

    ddr_param_bank #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_ID_W(CH_ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg        (cfg_if),
        .ch_busy    (ch_busy),
        .ch_start   (ch_start),
        .ch_pending (ch_pending),
        .act_ops    (act_ops),
        .act_stride (act_stride),
        .act_addr   (act_addr),
        .act_burst  (act_burst),
        .act_length (act_length),
        .act_mode   (act_mode)
`ifdef DDR_PARAM_READBACK_EN
        ,
        .rd_ch      (rd_ch),
        .rd_id      (rd_id),
        .rd_data    (rd_data)
`endif
    );

    // One accepted transfer; returns #1 after the transfer edge.
    task automatic cfg_write(input logic [1:0] ch, input logic [3:0] id, input logic [63:0] d);
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_id    = id;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        checks++;
        if (ch_start !== 2'b00) begin failures++; $display("FAIL reset_start got %b exp 00", ch_start); end
        checks++;
        if (ch_pending !== 2'b00) begin failures++; $display("FAIL reset_pending got %b exp 00", ch_pending); end
        checks++;
        if (act_ops !== '0 || act_addr !== '0 || act_mode !== '0) begin
            failures++; $display("FAIL reset_act got ops=%h addr=%h mode=%h exp 0", act_ops, act_addr, act_mode);
        end
        checks++;
        if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b exp 0", cfg_if.cfg_err); end
    endtask

    task automatic test_commit_ch0();
        cfg_write(2'd0, 4'h1, 64'h100);
        cfg_write(2'd0, 4'h2, 64'h40);
        cfg_write(2'd0, 4'h3, 64'h1_0000_0000);
        cfg_write(2'd0, 4'h4, 64'd16);
        checks++;
        if (act_ops[31:0] !== 32'h0) begin failures++; $display("FAIL shadow_hidden got %h exp 0", act_ops[31:0]); end
        cfg_write(2'd0, 4'hF, 64'h0);
        checks++;
        if (act_ops[31:0] !== 32'h100 || act_stride[31:0] !== 32'h40) begin
            failures++; $display("FAIL commit0_ops_stride got %h/%h exp 100/40", act_ops[31:0], act_stride[31:0]);
        end
        checks++;
        if (act_addr[32:0] !== 33'h1_0000_0000) begin failures++; $display("FAIL commit0_addr got %h exp 100000000", act_addr[32:0]); end
        checks++;
        if (act_burst[15:0] !== 16'd16) begin failures++; $display("FAIL commit0_burst got %0d exp 16", act_burst[15:0]); end
        checks++;
        if (ch_start !== 2'b01) begin failures++; $display("FAIL commit0_start got %b exp 01", ch_start); end
        checks++;
        if (act_ops[63:32] !== '0 || act_addr[65:33] !== '0 || act_burst[31:16] !== '0) begin
            failures++; $display("FAIL commit0_ch1_quiet got ops=%h addr=%h exp 0", act_ops[63:32], act_addr[65:33]);
        end
        idle(1);
        checks++;
        if (ch_start !== 2'b00) begin failures++; $display("FAIL commit0_single_pulse got %b exp 00", ch_start); end
    endtask

    task automatic test_pending();
        cfg_write(2'd1, 4'h1, 64'h55);
        ch_busy = 2'b10;
        cfg_write(2'd1, 4'hF, 64'h0);
        checks++;
        if (ch_pending !== 2'b10 || ch_start !== 2'b00) begin
            failures++; $display("FAIL pend_set got pend=%b start=%b exp 10/00", ch_pending, ch_start);
        end
        cfg_if.cfg_ch = 2'd1; #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin failures++; $display("FAIL pend_ready_ch1 got %b exp 0", cfg_if.cfg_ready); end
        cfg_if.cfg_ch = 2'd0; #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL pend_ready_ch0 got %b exp 1", cfg_if.cfg_ready); end
        cfg_write(2'd0, 4'h1, 64'h200);
        idle(3);
        checks++;
        if (ch_pending !== 2'b10 || act_ops[63:32] !== 32'h0) begin
            failures++; $display("FAIL pend_hold got pend=%b ops1=%h exp 10/0", ch_pending, act_ops[63:32]);
        end
        // Busy drops on ch1 in the same cycle as a ch0 commit: both must land.
        ch_busy = 2'b00;
        cfg_write(2'd0, 4'hF, 64'h0);
        checks++;
        if (ch_start !== 2'b11) begin failures++; $display("FAIL pend_resolve_start got %b exp 11", ch_start); end
        checks++;
        if (act_ops[63:32] !== 32'h55 || act_ops[31:0] !== 32'h200) begin
            failures++; $display("FAIL pend_resolve_ops got %h exp 0000005500000200", act_ops);
        end
        checks++;
        if (ch_pending !== 2'b00) begin failures++; $display("FAIL pend_clear got %b exp 00", ch_pending); end
        idle(1);
    endtask

    task automatic test_errors();
        cfg_write(2'd0, 4'h9, 64'hDEAD);
        checks++;
        if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL err_bad_id got %b exp 1", cfg_if.cfg_err); end
        idle(1);
        checks++;
        if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got %b exp 0", cfg_if.cfg_err); end
        cfg_if.cfg_ch = 2'd3; #1;
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin failures++; $display("FAIL err_ready_ch3 got %b exp 1", cfg_if.cfg_ready); end
        cfg_write(2'd3, 4'h1, 64'h777);
        checks++;
        if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL err_bad_ch got %b exp 1", cfg_if.cfg_err); end
        cfg_write(2'd0, 4'h4, 64'h1_0000);
        checks++;
        if (cfg_if.cfg_err !== 1'b1) begin failures++; $display("FAIL err_burst0 got %b exp 1", cfg_if.cfg_err); end
        cfg_write(2'd0, 4'hF, 64'h0);
        checks++;
        if (cfg_if.cfg_err !== 1'b0 || act_burst[15:0] !== 16'd16 || act_ops[31:0] !== 32'h200) begin
            failures++; $display("FAIL err_shadow0 got err=%b burst=%0d ops=%h exp 0/16/200",
                                 cfg_if.cfg_err, act_burst[15:0], act_ops[31:0]);
        end
        cfg_write(2'd1, 4'hF, 64'h0);
        checks++;
        if (act_ops[63:32] !== 32'h55) begin failures++; $display("FAIL err_shadow1 got %h exp 55", act_ops[63:32]); end
        idle(1);
    endtask

    task automatic test_mode();
        cfg_write(2'd0, 4'h6, 64'h3);
        cfg_write(2'd0, 4'hF, 64'h0);
        checks++;
        if (act_mode[3:0] !== 4'h3) begin failures++; $display("FAIL mode_commit got %h exp 3", act_mode[3:0]); end
        idle(20);
        checks++;
        if (act_mode[3:0] !== 4'h3 || act_mode[7:4] !== 4'h0) begin
            failures++; $display("FAIL mode_hold got %h exp 03", act_mode);
        end
    endtask

    task automatic test_reset_pending();
        logic spurious;
        ch_busy = 2'b01;
        cfg_write(2'd0, 4'hF, 64'h0);
        checks++;
        if (ch_pending !== 2'b01) begin failures++; $display("FAIL rstp_pending got %b exp 01", ch_pending); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ch_pending !== '0 || ch_start !== '0 || act_ops !== '0 || act_mode !== '0 || act_burst !== '0) begin
            failures++; $display("FAIL rstp_clear got pend=%b start=%b ops=%h mode=%h", ch_pending, ch_start, act_ops, act_mode);
        end
        checks++;
        if (cfg_if.cfg_err !== 1'b0) begin failures++; $display("FAIL rstp_err got %b exp 0", cfg_if.cfg_err); end
        @(negedge clk);
        ch_busy = 2'b00;
        rst_n = 1'b1;
        spurious = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ch_start !== 2'b00) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0 || ch_pending !== 2'b00 || act_ops !== '0) begin
            failures++; $display("FAIL rstp_no_start got spurious=%b pend=%b ops=%h exp 0", spurious, ch_pending, act_ops);
        end
    endtask

`ifdef DDR_PARAM_READBACK_EN
    task automatic test_readback();
        cfg_write(2'd1, 4'h5, 64'd1024);
        rd_ch = 2'd1;
        rd_id = 4'h5;
        idle(1);
        checks++;
        if (rd_data !== 64'd1024) begin failures++; $display("FAIL rb_length got %0d exp 1024", rd_data); end
        rd_id = 4'h9;
        idle(1);
        checks++;
        if (rd_data !== 64'd0) begin failures++; $display("FAIL rb_bad_id got %0d exp 0", rd_data); end
    endtask
`endif

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_id    = '0;
        cfg_if.cfg_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        test_commit_ch0();
        test_pending();
        test_errors();
        test_mode();
        test_reset_pending();
`ifdef DDR_PARAM_READBACK_EN
        test_readback();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_param_bank.md
Name: ddr_param_bank

Overview:
- Multi-channel parameter register bank for the DDR stream engines; replaces the single-channel fixed-field parameter decoder.
- A host-side config port writes per-channel shadow registers; an explicit commit copies the shadow set into the active set seen by that channel's DMA/FFT engine.
- Commits are deferred while the target engine is busy, so parameters never change mid-transfer.

Parameters:
- ADDR_WIDTH, 33, width of DDR init-address fields.
- DATA_W, 64, config data width; must be >= ADDR_WIDTH and >= 32.
- NUM_CH, 2, number of engine channels (1..4).
- CH_ID_W, 2, width of the channel select field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_valid  in  1  config write valid.
- cfg_ready  out  1  config write ready.
- cfg_ch  in  CH_ID_W  target channel.
- cfg_id  in  4  parameter id (see Behaviour).
- cfg_data  in  DATA_W  parameter value.
- cfg_err  out  1  one-cycle pulse: illegal write accepted and discarded.
- ch_busy  in  NUM_CH  engine busy, per channel.
- ch_start  out  NUM_CH  one-cycle pulse per channel when its active set is updated.
- ch_pending  out  NUM_CH  commit waiting on busy, per channel.
- act_ops  out  NUM_CH*32  active op count; channel c at [c*32+:32].
- act_stride  out  NUM_CH*32  active stride.
- act_addr  out  NUM_CH*ADDR_WIDTH  active init address.
- act_burst  out  NUM_CH*16  active burst size.
- act_length  out  NUM_CH*32  active transform length.
- act_mode  out  NUM_CH*4  active mode: [0] is_fft, [1] bypass_p2s, [3:2] reserved.

Behaviour:
- Handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !ch_pending[cfg_ch] (combinational); it is 1 when cfg_ch >= NUM_CH.
- Ids:
  - 1 ops = data[31:0]
  - 2 stride = data[31:0]
  - 3 addr = data[ADDR_WIDTH-1:0]
  - 4 burst = data[15:0]
  - 5 length = data[31:0]
  - 6 mode = data[3:0]
  - F commit
  - All others illegal.
- Shadow writes land at the transfer edge. Shadow registers hold their value across all other cycles; mode flags do not self-clear.
- Errors: a transfer is discarded with cfg_err = 1 in the following cycle when any of these holds:
  - illegal id;
  - cfg_ch >= NUM_CH;
  - burst write with data[15:0] == 0.
- Commit accepted at edge T with ch_busy[ch] == 0 at T:
  - active <= shadow at T;
  - ch_start[ch] = 1 for exactly the cycle after T.
- Commit accepted with ch_busy[ch] == 1:
  - ch_pending[ch] set at T.
  - On the first edge where ch_busy[ch] == 0: copy shadow to active, pulse ch_start[ch] in the next cycle, clear ch_pending.
  - Extra cycle of latency is acceptable.
- Channels are independent. A pending resolution on one channel and a commit/write on another in the same cycle both take effect.
- Shadow write and active copy on the same channel in the same cycle cannot occur: ready is low while pending.
- Reset (any time, including while pending): all shadow, active, pending, ch_start and cfg_err are 0. An in-flight commit is lost.
- Outputs are registered; there are no combinational paths from cfg_data to act_*.

Optional Feature:
- Macro: DDR_PARAM_READBACK_EN.
- Defined:
  - Adds ports rd_ch in CH_ID_W, rd_id in 4, rd_data out DATA_W.
  - rd_data returns the shadow value for ids 1–6, zero-extended, registered, 1-cycle latency.
  - Returns 0 for illegal id or channel.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Ch0 writes ops = 0x100, stride = 0x40, addr = 0x1_0000_0000, burst = 16, then commit with busy = 0 -> act_* of ch0 match next cycle; ch_start[0] pulses exactly once; ch1 outputs stay 0.
- Ch1 busy = 1, commit -> ch_pending[1] = 1, cfg_ready low for cfg_ch = 1 and high for cfg_ch = 0. Drop busy at cycle 10 -> active updates at cycle 11, start pulse at cycle 11, pending cleared.
- Write id 0x9, cfg_ch = 3 with NUM_CH = 2, and burst = 0 -> three cfg_err pulses; shadow unchanged (verified by commit or readback).
- Mode write 0x3 then commit, then 20 idle cycles -> act_mode stays 0x3 (no self-clear).
- Assert rst_n low while ch0 pending -> all outputs 0; after release, no spurious ch_start.
- With DDR_PARAM_READBACK_EN defined: write length = 1024 on ch1, read rd_ch = 1, rd_id = 5 -> rd_data = 1024 one cycle later.
